// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue control and pipeline interlock for the mult/div unit.
// Counts the nominal unit latency, then waits on the unit's own busy flag.
module md_issue_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [3:0] e_op,
  input  logic       d_is_md,
  input  logic       md_busy,
  output logic [3:0] md_op,
  output logic       md_start,
  output logic       stall,
  output logic [3:0] busy_cnt,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt_nx;
  logic       err_nx;
  logic       is_md;
  logic       is_mul;
  logic       is_div;
  logic       idle;
  logic       issue_ok;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    unique case (1'b1)
      (e_op inside {4'd1, 4'd2}): is_mul = 1'b1;
      (e_op inside {4'd3, 4'd4}): is_div = 1'b1;
      default: ;
    endcase
    is_md = e_op inside {[4'd1:4'd8]};
  end

  assign idle     = (state == IDLE);
  assign issue_ok = e_valid & is_md & idle;
  assign md_op    = issue_ok ? e_op : 4'd0;
  // No start pulse may escape while reset is held low.
  assign md_start = issue_ok & (is_mul | is_div) & reset;
  assign stall    = d_is_md & (md_start | ~idle | md_busy);

  always_comb begin
    state_nx = state;
    cnt_nx   = busy_cnt;
    err_nx   = err | (e_valid & is_md & ~idle);
    unique case (state)
      IDLE: begin
        if (md_start) begin
          state_nx = RUN;
          cnt_nx   = is_mul ? MUL_CNT : DIV_CNT;
        end
      end
      RUN: begin
        if (busy_cnt <= 4'd1) begin
          cnt_nx   = 4'd0;
          state_nx = md_busy ? DRAIN : IDLE;
        end else begin
          cnt_nx = busy_cnt - 4'd1;
        end
      end
      DRAIN: begin
        cnt_nx = 4'd0;
        if (!md_busy) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy_cnt <= 4'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      busy_cnt <= cnt_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed scenarios plus random traffic for md_issue_ctrl.
// Expected values come from a timestamp model of the unit's busy window.
module tb_md_issue_ctrl;

  localparam int MUL = 5;
  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       e_valid = 1'b0;
  logic [3:0] e_op = 4'd0;
  logic       d_is_md = 1'b0;
  logic       md_busy = 1'b0;
  logic [3:0] md_op;
  logic       md_start;
  logic       stall;
  logic [3:0] busy_cnt;
  logic       err;

  int n_checks = 0;
  int n_err = 0;

  // model: unit counted busy from m_t+1 through m_t+m_lat, then until busy drops
  bit m_active = 1'b0;
  int m_t = 0;
  int m_lat = 0;
  int m_now = 0;
  bit m_err = 1'b0;

  logic [3:0] exp_op;
  logic       exp_start;
  logic       exp_stall;
  logic [3:0] exp_cnt;
  logic       exp_err;
  bit         cur_md;

  md_issue_ctrl dut (
    .clk(clk),
    .reset(reset),
    .e_valid(e_valid),
    .e_op(e_op),
    .d_is_md(d_is_md),
    .md_busy(md_busy),
    .md_op(md_op),
    .md_start(md_start),
    .stall(stall),
    .busy_cnt(busy_cnt),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic predict();
    bit ok;
    int end_c;
    cur_md = e_valid && (e_op >= 4'd1) && (e_op <= 4'd8);
    ok = cur_md && !m_active;
    exp_op = ok ? e_op : 4'd0;
    exp_start = ok && (e_op <= 4'd4) && reset;
    exp_stall = d_is_md && (exp_start || m_active || md_busy);
    end_c = m_t + m_lat;
    exp_cnt = (m_active && m_now <= end_c) ? 4'(end_c + 1 - m_now) : 4'd0;
    exp_err = m_err;
  endtask

  task automatic apply(input bit ev, input int op, input bit dm, input bit mb);
    @(negedge clk);
    e_valid = ev;
    e_op = 4'(op);
    d_is_md = dm;
    md_busy = mb;
    #1;
    predict();
  endtask

  task automatic tick();
    if (reset) begin
      if (cur_md && m_active) m_err = 1'b1;
      if (m_active && m_now >= m_t + m_lat && !md_busy) m_active = 1'b0;
      if (exp_start) begin
        m_active = 1'b1;
        m_t = m_now;
        m_lat = (e_op <= 4'd2) ? MUL : DIV;
      end
    end else begin
      model_reset();
    end
    m_now++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    e_valid = 1'b0;
    e_op = 4'd0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    e_valid = 1'b1;
    e_op = 4'd2;
    d_is_md = 1'b1;
    md_busy = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #2;
    n_checks++; if (busy_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", busy_cnt); end
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0b want 0", err); end
    n_checks++; if (md_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %0b want 0", md_start); end
    n_checks++; if (md_op !== 4'd2) begin n_err++; $display("FAIL rst_op: got %0d want 2", md_op); end
    n_checks++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_busy: got %0b want 1", stall); end
    md_busy = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_free: got %0b want 0", stall); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt_edge: got %0d want 0", busy_cnt); end
    @(negedge clk);
    e_valid = 1'b0;
    e_op = 4'd0;
    d_is_md = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_mult();
    do_reset();
    apply(1, 2, 0, 0);
    n_checks++; if (md_start !== 1'b1) begin n_err++; $display("FAIL mult_start: got %0b want 1", md_start); end
    n_checks++; if (md_op !== 4'd2) begin n_err++; $display("FAIL mult_op: got %0d want 2", md_op); end
    tick();
    for (int k = 5; k >= 1; k--) begin
      apply(0, 0, 1, 0);
      n_checks++; if (busy_cnt !== 4'(k)) begin n_err++; $display("FAIL mult_cnt: got %0d want %0d", busy_cnt, k); end
      tick();
    end
    apply(0, 0, 1, 0);
    n_checks++; if (busy_cnt !== 4'd0) begin n_err++; $display("FAIL mult_done_cnt: got %0d want 0", busy_cnt); end
    n_checks++; if (stall !== 1'b0) begin n_err++; $display("FAIL mult_done_stall: got %0b want 0", stall); end
    tick();
  endtask

  task automatic test_div_stall();
    do_reset();
    apply(1, 4, 1, 0);
    n_checks++; if (stall !== 1'b1) begin n_err++; $display("FAIL div_stall_c0: got %0b want 1", stall); end
    tick();
    for (int c = 1; c <= 10; c++) begin
      apply(0, 0, 1, c <= 9);
      n_checks++; if (stall !== 1'b1) begin n_err++; $display("FAIL div_stall_c%0d: got %0b want 1", c, stall); end
      n_checks++; if (busy_cnt !== exp_cnt) begin n_err++; $display("FAIL div_cnt_c%0d: got %0d want %0d", c, busy_cnt, exp_cnt); end
      tick();
    end
    apply(0, 0, 1, 0);
    n_checks++; if (stall !== 1'b0) begin n_err++; $display("FAIL div_stall_c11: got %0b want 0", stall); end
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    apply(1, 1, 1, 0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      apply(0, 0, 1, 1);
      n_checks++; if (stall !== 1'b1) begin n_err++; $display("FAIL drain_stall_c%0d: got %0b want 1", c, stall); end
      n_checks++; if (busy_cnt !== 4'(c <= 5 ? 6 - c : 0)) begin n_err++; $display("FAIL drain_cnt_c%0d: got %0d want %0d", c, busy_cnt, (c <= 5 ? 6 - c : 0)); end
      tick();
    end
    apply(0, 0, 1, 0);
    n_checks++; if (stall !== 1'b1) begin n_err++; $display("FAIL drain_last: got %0b want 1", stall); end
    tick();
    apply(0, 0, 1, 0);
    n_checks++; if (stall !== 1'b0) begin n_err++; $display("FAIL drain_idle: got %0b want 0", stall); end
    tick();
    apply(1, 3, 0, 0);
    n_checks++; if (md_start !== 1'b1) begin n_err++; $display("FAIL drain_reissue: got %0b want 1", md_start); end
    tick();
  endtask

  task automatic test_violation();
    do_reset();
    apply(1, 2, 0, 0);
    tick();
    apply(1, 6, 0, 0);
    n_checks++; if (md_op !== 4'd0) begin n_err++; $display("FAIL viol_op: got %0d want 0", md_op); end
    n_checks++; if (md_start !== 1'b0) begin n_err++; $display("FAIL viol_start: got %0b want 0", md_start); end
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL viol_err_early: got %0b want 0", err); end
    tick();
    apply(0, 0, 0, 0);
    n_checks++; if (err !== 1'b1) begin n_err++; $display("FAIL viol_err_set: got %0b want 1", err); end
    n_checks++; if (busy_cnt !== 4'd4) begin n_err++; $display("FAIL viol_cnt: got %0d want 4", busy_cnt); end
    tick();
    repeat (8) begin apply(0, 0, 0, 0); tick(); end
    apply(0, 0, 0, 0);
    n_checks++; if (err !== 1'b1) begin n_err++; $display("FAIL viol_err_hold: got %0b want 1", err); end
    tick();
    do_reset();
    #1;
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL viol_err_clr: got %0b want 0", err); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    apply(1, 4, 0, 0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      apply(0, 0, 1, 0);
      tick();
    end
    apply(0, 0, 1, 0);
    n_checks++; if (busy_cnt !== 4'd6) begin n_err++; $display("FAIL mid_pre: got %0d want 6", busy_cnt); end
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (busy_cnt !== 4'd0) begin n_err++; $display("FAIL mid_async_cnt: got %0d want 0", busy_cnt); end
    n_checks++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_async_stall: got %0b want 0", stall); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply(1, 2, 0, 0);
    tick();
    apply(0, 0, 0, 0);
    n_checks++; if (busy_cnt !== 4'd5) begin n_err++; $display("FAIL mid_restart: got %0d want 5", busy_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(1, 7, 0, 0);
    n_checks++; if (md_op !== 4'd7) begin n_err++; $display("FAIL b2b_mthi_op: got %0d want 7", md_op); end
    n_checks++; if (md_start !== 1'b0) begin n_err++; $display("FAIL b2b_mthi_start: got %0b want 0", md_start); end
    tick();
    apply(1, 2, 0, 0);
    n_checks++; if (md_start !== 1'b1) begin n_err++; $display("FAIL b2b_mult_start: got %0b want 1", md_start); end
    tick();
    repeat (5) begin apply(0, 0, 0, 0); tick(); end
    apply(1, 4, 0, 0);
    n_checks++; if (md_start !== 1'b1) begin n_err++; $display("FAIL b2b_nogap: got %0b want 1", md_start); end
    tick();
    apply(1, 12, 0, 0);
    n_checks++; if (md_op !== 4'd0) begin n_err++; $display("FAIL b2b_op12: got %0d want 0", md_op); end
    tick();
    apply(0, 0, 0, 0);
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL b2b_err: got %0b want 0", err); end
    n_checks++; if (busy_cnt !== 4'd9) begin n_err++; $display("FAIL b2b_cnt: got %0d want 9", busy_cnt); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 9) < 4);
      n_checks++; if (md_op !== exp_op) begin n_err++; $display("FAIL rnd_op@%0d: got %0d want %0d", i, md_op, exp_op); end
      n_checks++; if (md_start !== exp_start) begin n_err++; $display("FAIL rnd_start@%0d: got %0b want %0b", i, md_start, exp_start); end
      n_checks++; if (stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall@%0d: got %0b want %0b", i, stall, exp_stall); end
      n_checks++; if (busy_cnt !== exp_cnt) begin n_err++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, busy_cnt, exp_cnt); end
      n_checks++; if (err !== exp_err) begin n_err++; $display("FAIL rnd_err@%0d: got %0b want %0b", i, err, exp_err); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_stall();
    test_drain();
    test_violation();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
